// File: rtl/hs_tx_byte_sequencer_pkg.sv
// Shared types and helpers for the HS transmit byte sequencer.
// The CSUM state exists only when HS_TX_CHECKSUM_EN is defined.
package hs_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_SYNC,
        ST_DATA,
`ifdef HS_TX_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_TRAIL
    } hs_tx_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hB8;
    localparam logic [7:0] IDLE_BYTE_DEF = 8'h00;
    localparam int         TRAIL_MAX_W   = 64;

    // Every trailer bit is the inverse of the MSB of the last byte on the line (w in 1..64).
    function automatic logic [TRAIL_MAX_W-1:0] trailer_byte(input logic [TRAIL_MAX_W-1:0] b,
                                                           input int w);
        logic [TRAIL_MAX_W-1:0] s;
        s = b << (TRAIL_MAX_W - w);
        return {TRAIL_MAX_W{~s[TRAIL_MAX_W-1]}};
    endfunction

    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/hs_tx_byte_sequencer_if.sv
// Payload-source and serializer-side signals of the HS transmit byte sequencer.
// master: payload source / line observer; slave: the sequencer itself.
interface hs_tx_byte_sequencer_if #(
    parameter int W = 8
);
    logic         TxRequestHS;
    logic [W-1:0] TxDataIn;
    logic         TxValidIn;
    logic         TxReadyHS;
    logic [W-1:0] TxByteHS;
    logic         TxHSActive;
    logic         TxDone;
    logic         TxUnderrun;

    modport master (
        output TxRequestHS, TxDataIn, TxValidIn,
        input  TxReadyHS, TxByteHS, TxHSActive, TxDone, TxUnderrun
    );

    modport slave (
        input  TxRequestHS, TxDataIn, TxValidIn,
        output TxReadyHS, TxByteHS, TxHSActive, TxDone, TxUnderrun
    );
endinterface

// File: rtl/hs_tx_byte_sequencer_checksum.sv
// Running XOR of accepted payload bytes; compiled only with HS_TX_CHECKSUM_EN.
// A clear and an enable in the same cycle restart the sum at din_i.
`ifdef HS_TX_CHECKSUM_EN
module hs_tx_checksum #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] sum_o
);
    logic [W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = (clr_i ? '0 : sum_q) ^ (en_i ? din_i : '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sum_q <= '0;
        else         sum_q <= sum_d;
    end

    assign sum_o = sum_q;
endmodule
`endif

// File: rtl/hs_tx_byte_sequencer.sv
// HS transmit byte sequencer: frames payload as PREP/SYNC leader, payload, trailer.
// Define HS_TX_CHECKSUM_EN to append an XOR checksum byte (CSUM) after the payload.
module hs_tx_byte_sequencer
    import hs_tx_pkg::*;
#(
    parameter int           W         = 8,
    parameter int           PREP_CYC  = 4,
    parameter int           TRAIL_LEN = 2,
    parameter logic [W-1:0] SYNC_BYTE = W'(SYNC_BYTE_DEF),
    parameter logic [W-1:0] IDLE_BYTE = W'(IDLE_BYTE_DEF)
) (
    input  logic                    TxByteClk,
    input  logic                    Tx_RST,
    hs_tx_byte_sequencer_if.slave   bus
);
    localparam int             CNT_W      = cnt_width(PREP_CYC, TRAIL_LEN);
    localparam logic [CNT_W-1:0] PREP_LOAD  = CNT_W'(PREP_CYC - 1);
    localparam logic [CNT_W-1:0] TRAIL_LOAD = CNT_W'(TRAIL_LEN - 1);

    hs_tx_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     byte_q, byte_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic             urun_q, urun_d;
    logic             req, valid, ready, accept;
    logic [W-1:0]     trail_fill;

    assign req        = bus.TxRequestHS;
    assign valid      = bus.TxValidIn;
    assign accept     = ready & valid;
    assign trail_fill = W'(trailer_byte(TRAIL_MAX_W'(byte_q), W));

`ifdef HS_TX_CHECKSUM_EN
    logic [W-1:0] sum;
    logic [W-1:0] csum_byte;

    hs_tx_checksum #(.W(W)) u_csum (
        .clk_i  (TxByteClk),
        .rst_ni (Tx_RST),
        .clr_i  (state_q == ST_SYNC),
        .en_i   (accept),
        .din_i  (bus.TxDataIn),
        .sum_o  (sum)
    );
    // Leaving from SYNC means nothing was accepted, so the stale sum must not leak out.
    assign csum_byte = (state_q == ST_SYNC) ? '0 : sum;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
        active_d = active_q;
        done_d   = 1'b0;
        urun_d   = urun_q;
        ready    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                byte_d = IDLE_BYTE;
                if (req) begin
                    state_d  = ST_PREP;
                    cnt_d    = PREP_LOAD;
                    active_d = 1'b1;
                    urun_d   = 1'b0;
                end
            end
            ST_PREP: begin
                if (!req) begin
                    state_d  = ST_IDLE;
                    byte_d   = IDLE_BYTE;
                    active_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = ST_SYNC;
                    byte_d  = SYNC_BYTE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SYNC, ST_DATA: begin
                ready = req;
                if (accept) begin
                    state_d = ST_DATA;
                    byte_d  = bus.TxDataIn;
                end else begin
                    // A gap while still requested cannot be shown on the line: close the burst.
                    if (req) urun_d = 1'b1;
`ifdef HS_TX_CHECKSUM_EN
                    state_d = ST_CSUM;
                    byte_d  = csum_byte;
`else
                    state_d = ST_TRAIL;
                    byte_d  = trail_fill;
                    cnt_d   = TRAIL_LOAD;
`endif
                end
            end
`ifdef HS_TX_CHECKSUM_EN
            ST_CSUM: begin
                state_d = ST_TRAIL;
                byte_d  = trail_fill;
                cnt_d   = TRAIL_LOAD;
            end
`endif
            ST_TRAIL: begin
                if (cnt_q == '0) begin
                    state_d  = ST_IDLE;
                    byte_d   = IDLE_BYTE;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                byte_d   = IDLE_BYTE;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge TxByteClk or negedge Tx_RST) begin
        if (!Tx_RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            byte_q   <= IDLE_BYTE;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            urun_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
            active_q <= active_d;
            done_q   <= done_d;
            urun_q   <= urun_d;
        end
    end

    assign bus.TxReadyHS  = ready;
    assign bus.TxByteHS   = byte_q;
    assign bus.TxHSActive = active_q;
    assign bus.TxDone     = done_q;
    assign bus.TxUnderrun = urun_q;
endmodule

// File: tb/tb_hs_tx_byte_sequencer.sv
// Scoreboard bench for hs_tx_byte_sequencer: the driver pushes the expected line
// sequence of each burst, a negedge monitor pops and compares every active cycle.
module tb_hs_tx_byte_sequencer;
    localparam int W         = 8;
    localparam int PREP_CYC  = 4;
    localparam int TRAIL_LEN = 2;
`ifdef HS_TX_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    typedef struct {
        logic [7:0] b;
        logic       rdy;
        logic       urun;
        logic       done_after;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t expq[$];

    always #5 clk = ~clk;

    hs_tx_byte_sequencer_if #(.W(W)) bus ();

    hs_tx_byte_sequencer #(
        .W(W), .PREP_CYC(PREP_CYC), .TRAIL_LEN(TRAIL_LEN),
        .SYNC_BYTE(8'hB8), .IDLE_BYTE(8'h00)
    ) dut (
        .TxByteClk (clk),
        .Tx_RST    (rst_n),
        .bus       (bus)
    );

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] b, input logic rdy, input logic urun, input logic dn);
        exp_t e;
        e.b = b; e.rdy = rdy; e.urun = urun; e.done_after = dn;
        expq.push_back(e);
    endtask

    // Reference: leader, payload, optional XOR byte, trailer derived from the last byte.
    task automatic model_burst(input logic [7:0] pl[$], input bit urun);
        logic [7:0] last;
        logic [7:0] x;
        int n;
        n = pl.size();
        x = 8'h00;
        for (int i = 0; i < PREP_CYC; i++) push(8'h00, 1'b0, 1'b0, 1'b0);
        push(8'hB8, n > 0, 1'b0, 1'b0);
        last = 8'hB8;
        for (int i = 0; i < n; i++) begin
            push(pl[i], urun ? 1'b1 : (i + 1 < n), 1'b0, 1'b0);
            x    = x ^ pl[i];
            last = pl[i];
        end
        if (CS != 0) begin
            push(x, 1'b0, urun, 1'b0);
            last = x;
        end
        for (int j = 0; j < TRAIL_LEN; j++)
            push(last[7] ? 8'h00 : 8'hFF, 1'b0, urun, j == TRAIL_LEN - 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_burst(input logic [7:0] pl[$], input bit urun);
        model_burst(pl, urun);
        bus.TxRequestHS = 1'b1;
        for (int i = 0; i < PREP_CYC + 1; i++) begin
            bus.TxValidIn = 1'($urandom);
            bus.TxDataIn  = 8'($urandom);
            tick();
        end
        foreach (pl[i]) begin
            bus.TxValidIn = 1'b1;
            bus.TxDataIn  = pl[i];
            tick();
        end
        bus.TxValidIn = 1'b0;
        bus.TxDataIn  = 8'($urandom);
        if (urun) tick();
        bus.TxRequestHS = 1'b0;
        repeat (1 + CS + TRAIL_LEN + int'($urandom_range(0, 3))) tick();
    endtask

    task automatic run_abort(input int k);
        for (int i = 0; i < k; i++) push(8'h00, 1'b0, 1'b0, 1'b0);
        bus.TxRequestHS = 1'b1;
        repeat (k) tick();
        bus.TxRequestHS = 1'b0;
        repeat (2 + int'($urandom_range(0, 2))) tick();
    endtask

    task automatic run_reset_mid_data();
        for (int i = 0; i < PREP_CYC; i++) push(8'h00, 1'b0, 1'b0, 1'b0);
        push(8'hB8, 1'b1, 1'b0, 1'b0);
        push(8'h5A, 1'b1, 1'b0, 1'b0);
        push(8'hC3, 1'b1, 1'b0, 1'b0);
        bus.TxRequestHS = 1'b1;
        repeat (PREP_CYC + 1) tick();
        bus.TxValidIn = 1'b1;
        bus.TxDataIn  = 8'h5A;
        tick();
        bus.TxDataIn  = 8'hC3;
        tick();
        bus.TxDataIn  = 8'h77;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk8("rst_mid_byte", bus.TxByteHS, 8'h00);
        chk1("rst_mid_active", bus.TxHSActive, 1'b0);
        chk1("rst_mid_done", bus.TxDone, 1'b0);
        chk1("rst_mid_urun", bus.TxUnderrun, 1'b0);
        bus.TxRequestHS = 1'b0;
        bus.TxValidIn   = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
    endtask

    // Monitor: compares one expected entry per active cycle, idle values otherwise.
    initial begin
        exp_t e;
        logic done_exp;
        logic urun_exp;
        done_exp = 1'b0;
        urun_exp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_exp = 1'b0;
                urun_exp = 1'b0;
            end else begin
                chk1("done", bus.TxDone, done_exp);
                done_exp = 1'b0;
                if (bus.TxHSActive) begin
                    if (expq.size() == 0) begin
                        chk1("unexpected_active", bus.TxHSActive, 1'b0);
                    end else begin
                        e = expq.pop_front();
                        chk8("line_byte", bus.TxByteHS, e.b);
                        chk1("ready", bus.TxReadyHS, e.rdy);
                        chk1("underrun", bus.TxUnderrun, e.urun);
                        done_exp = e.done_after;
                        urun_exp = e.urun;
                    end
                end else begin
                    chk8("idle_byte", bus.TxByteHS, 8'h00);
                    chk1("idle_ready", bus.TxReadyHS, 1'b0);
                    chk1("idle_underrun", bus.TxUnderrun, urun_exp);
                end
            end
        end
    end

    initial begin
        logic [7:0] q[$];
        int kind;
        int n;
        bus.TxRequestHS = 1'b0;
        bus.TxValidIn   = 1'b0;
        bus.TxDataIn    = 8'h00;
        #1;
        chk8("reset_byte", bus.TxByteHS, 8'h00);
        chk1("reset_active", bus.TxHSActive, 1'b0);
        chk1("reset_done", bus.TxDone, 1'b0);
        chk1("reset_urun", bus.TxUnderrun, 1'b0);
        chk1("reset_ready", bus.TxReadyHS, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        q = '{8'hAB, 8'hCD, 8'hEF};
        run_burst(q, 1'b0);
        q = {};
        run_burst(q, 1'b0);
        q = '{8'h12};
        run_burst(q, 1'b1);
        run_abort(2);
        q = '{8'h0F, 8'hF0, 8'h81};
        run_burst(q, 1'b0);
        run_reset_mid_data();

        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 9));
            q = {};
            if (kind == 0) begin
                run_abort(int'($urandom_range(1, PREP_CYC)));
            end else if (kind <= 2) begin
                n = int'($urandom_range(1, 5));
                for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                run_burst(q, 1'b1);
            end else begin
                n = int'($urandom_range(0, 6));
                for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                run_burst(q, 1'b0);
            end
        end

        for (int i = 0; i < 50 && expq.size() != 0; i++) tick();
        if (expq.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expected line bytes never appeared, required 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
